// File: rtl/dram_stream_bridge_if.sv
// Bundle of the stream, core-bus and control signals of dram_stream_bridge.
// slave  : the bridge side (takes stream/core inputs, drives ready/data/status).
// master : the environment side (stream source, core, result sink, controller).
// Signals:
//   start_load, len_m1            sequence request and length-minus-one
//   in_data, in_valid, in_ready   upstream byte stream
//   core_en, coreS                core run enable / core finished flag
//   DRAM_addr, DRAM_dataOut,
//   memREAD, memWRITE, DRAM_dataIn core RAM port
//   out_data, out_valid, out_ready downstream byte stream
//   busy, done                    status
interface dram_stream_bridge_if #(
  parameter int WIDTH = 8
);
  logic             start_load;
  logic [WIDTH-1:0] len_m1;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             core_en;
  logic [WIDTH-1:0] DRAM_addr;
  logic [WIDTH-1:0] DRAM_dataOut;
  logic             memREAD;
  logic             memWRITE;
  logic             coreS;
  logic [WIDTH-1:0] DRAM_dataIn;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport slave (
    input  start_load, len_m1, in_data, in_valid,
           DRAM_addr, DRAM_dataOut, memREAD, memWRITE, coreS, out_ready,
    output in_ready, core_en, DRAM_dataIn, out_data, out_valid, busy, done
  );

  modport master (
    output start_load, len_m1, in_data, in_valid,
           DRAM_addr, DRAM_dataOut, memREAD, memWRITE, coreS, out_ready,
    input  in_ready, core_en, DRAM_dataIn, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/dram_stream_bridge.sv
// dram_stream_bridge: owns the core's 2**WIDTH x WIDTH data RAM.
// Sequence: IDLE -> LOAD (fill RAM from the input stream) -> RUN (core owns
// RAM until coreS) -> DUMP_RD/DUMP_OUT (stream RAM out) -> IDLE.
// Ports:
//   Clk  rising-edge clock
//   Rst  asynchronous active-high reset (RAM contents are preserved)
//   bus  dram_stream_bridge_if.slave (stream, core port, control, status)
module dram_stream_bridge #(
  parameter int WIDTH = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  dram_stream_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP_RD,
    DUMP_OUT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ptr;
  logic [WIDTH-1:0] len;
  logic             coreEn;
  logic [WIDTH-1:0] dataInReg;
  logic [WIDTH-1:0] outData;
  logic             outValid;
  logic             doneReg;

  logic [WIDTH-1:0] ram [2**WIDTH];

  logic             ramWe;
  logic [WIDTH-1:0] ramWaddr;
  logic [WIDTH-1:0] ramWdata;

  // Single write port shared by the loader and the core; the two owners
  // are never active in the same state.
  always_comb begin
    ramWe    = 1'b0;
    ramWaddr = ptr;
    ramWdata = bus.in_data;
    if (state == LOAD && bus.in_valid) begin
      ramWe = 1'b1;
    end else if (state == RUN && bus.memWRITE) begin
      ramWe    = 1'b1;
      ramWaddr = bus.DRAM_addr;
      ramWdata = bus.DRAM_dataOut;
    end
  end

  // RAM has no reset so its contents survive Rst.
  always_ff @(posedge Clk) begin
    if (ramWe) begin
      ram[ramWaddr] <= ramWdata;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      ptr       <= '0;
      len       <= '0;
      coreEn    <= 1'b0;
      dataInReg <= '0;
      outData   <= '0;
      outValid  <= 1'b0;
      doneReg   <= 1'b0;
    end else begin
      doneReg <= 1'b0;

      // Reads sample the array before this edge's write lands, which gives
      // read-before-write on a same-address read+write.
      if (state == RUN && bus.memREAD) begin
        dataInReg <= ram[bus.DRAM_addr];
      end

      case (state)
        IDLE: begin
          if (bus.start_load) begin
            len   <= bus.len_m1;
            ptr   <= '0;
            state <= LOAD;
          end
        end

        LOAD: begin
          if (bus.in_valid) begin
            if (ptr == len) begin
              ptr    <= '0;
              coreEn <= 1'b1;
              state  <= RUN;
            end else begin
              ptr <= ptr + WIDTH'(1);
            end
          end
        end

        RUN: begin
          if (bus.coreS) begin
            coreEn <= 1'b0;
            state  <= DUMP_RD;
          end
        end

        DUMP_RD: begin
          outData  <= ram[ptr];
          outValid <= 1'b1;
          state    <= DUMP_OUT;
        end

        DUMP_OUT: begin
          if (bus.out_ready) begin
            outValid <= 1'b0;
            // Compare against the latched length rather than len+1 so a
            // full 2**WIDTH transfer needs no extra counter bit.
            if (ptr == len) begin
              doneReg <= 1'b1;
              ptr     <= '0;
              state   <= IDLE;
            end else begin
              ptr   <= ptr + WIDTH'(1);
              state <= DUMP_RD;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == LOAD);
  assign bus.busy        = (state != IDLE);
  assign bus.core_en     = coreEn;
  assign bus.DRAM_dataIn = dataInReg;
  assign bus.out_data    = outData;
  assign bus.out_valid   = outValid;
  assign bus.done        = doneReg;

endmodule
